// File: rtl/data_memory_unit_if.sv
// Request/response bus of the MemoryAccess-stage data memory.
// A request transfers on a rising edge where reqValid && reqReady; the response is a one-cycle respValid pulse with no backpressure.
interface data_memory_unit_if #(
   parameter int ADDR_WIDTH = 64
);
   logic                  reqValid;
   logic                  reqReady;
   logic                  reqWrite;
   logic [ADDR_WIDTH-1:0] reqAddress;
   logic [63:0]           reqWriteData;
   logic [1:0]            reqSize;
   logic                  reqSignExtended;
   logic                  respValid;
   logic [63:0]           respReadData;
   logic                  respError;

   modport master (
      output reqValid, reqWrite, reqAddress, reqWriteData, reqSize, reqSignExtended,
      input  reqReady, respValid, respReadData, respError
   );

   modport slave (
      input  reqValid, reqWrite, reqAddress, reqWriteData, reqSize, reqSignExtended,
      output reqReady, respValid, respReadData, respError
   );
endinterface

// File: rtl/data_memory_unit.sv
// Byte-addressable data memory on a 64-bit word array; word-crossing accesses
// are split over two cycles, illegal requests return an error response.
module data_memory_unit #(
   parameter int DEPTH_BYTES = 2048,
   parameter int ADDR_WIDTH  = 64
) (
   input  logic                clk,
   input  logic                resetN,
   data_memory_unit_if.slave   bus,
   output logic                dbg_state
);
   localparam int AW    = $clog2(DEPTH_BYTES);
   localparam int WORDS = DEPTH_BYTES / 8;
   localparam int WIW   = AW - 3;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_BYTES);

   typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

   state_t state, state_n;

   logic [63:0]    mem [WORDS];

   logic [WIW-1:0] req_w, cap_w, mem_idx;
   logic [2:0]     req_o, cap_off, sel_off;
   logic [1:0]     cap_size, sel_size;
   logic           cap_sign, cap_write, cap_en;
   logic [63:0]    cap_wdata, sel_wdata;
   logic [3:0]     req_n;
   logic [AW:0]    req_end;
   logic           addr_hi_err, range_err, sign_err, req_err, req_cross, acc;
   logic [15:0]    lane_mask;
   logic [127:0]   lane_data;
   logic           mem_we;
   logic [7:0]     mem_be;
   logic [63:0]    mem_wdata, mem_rdata, rd_shift, merged;
   logic [6:0]     hi_shift;
   logic [63:0]    hold, hold_n, resp_d, resp_d_n;
   logic           resp_v, resp_v_n, resp_e, resp_e_n;

   function automatic logic [15:0] size_mask(input logic [1:0] s);
      case (s)
         2'd0:    size_mask = 16'h0001;
         2'd1:    size_mask = 16'h0003;
         2'd2:    size_mask = 16'h000F;
         default: size_mask = 16'h00FF;
      endcase
   endfunction

   function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] s,
                                          input logic sg);
      case (s)
         2'd0:    extend = sg ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
         2'd1:    extend = sg ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
         2'd2:    extend = sg ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
         default: extend = d;
      endcase
   endfunction

   // Request decode; the range check is only meaningful once the high bits are clear.
   assign req_w       = bus.reqAddress[AW-1:3];
   assign req_o       = bus.reqAddress[2:0];
   assign req_n       = 4'd1 << bus.reqSize;
   assign req_end     = {1'b0, bus.reqAddress[AW-1:0]} + {{(AW-3){1'b0}}, req_n};
   assign addr_hi_err = (bus.reqAddress >> AW) != '0;
   assign range_err   = req_end > DEPTH_L;
   assign sign_err    = !bus.reqWrite && (bus.reqSize == 2'd3) && !bus.reqSignExtended;
   assign req_err     = addr_hi_err | range_err | sign_err;
   assign req_cross   = ({1'b0, req_o} + req_n) > 4'd8;

   assign bus.reqReady = (state == IDLE);
   assign acc          = bus.reqValid && (state == IDLE) && resetN;
   assign dbg_state    = (state == SPLIT);

   // Lane mask/data span two words: [7:0]/[63:0] hit word w, the upper half word w+1.
   assign sel_off   = (state == SPLIT) ? cap_off   : req_o;
   assign sel_size  = (state == SPLIT) ? cap_size  : bus.reqSize;
   assign sel_wdata = (state == SPLIT) ? cap_wdata : bus.reqWriteData;
   assign lane_mask = size_mask(sel_size) << sel_off;
   assign lane_data = {64'd0, sel_wdata} << {sel_off, 3'b000};

   assign mem_rdata = mem[mem_idx];
   assign rd_shift  = mem_rdata >> {req_o, 3'b000};
   assign hi_shift  = {4'd8 - {1'b0, cap_off}, 3'b000};
   assign merged    = hold | (mem_rdata << hi_shift);

   always_comb begin
      state_n   = state;
      mem_idx   = req_w;
      mem_we    = 1'b0;
      mem_be    = 8'd0;
      mem_wdata = 64'd0;
      hold_n    = hold;
      resp_v_n  = 1'b0;
      resp_e_n  = 1'b0;
      resp_d_n  = 64'd0;
      cap_en    = 1'b0;
      case (state)
         IDLE: begin
            if (acc) begin
               if (req_err) begin
                  resp_v_n = 1'b1;
                  resp_e_n = 1'b1;
               end else begin
                  if (bus.reqWrite) begin
                     mem_we    = 1'b1;
                     mem_be    = lane_mask[7:0];
                     mem_wdata = lane_data[63:0];
                  end
                  if (req_cross) begin
                     state_n = SPLIT;
                     cap_en  = 1'b1;
                     if (!bus.reqWrite) hold_n = rd_shift;
                  end else begin
                     resp_v_n = 1'b1;
                     if (!bus.reqWrite)
                        resp_d_n = extend(rd_shift, bus.reqSize, bus.reqSignExtended);
                  end
               end
            end
         end
         SPLIT: begin
            mem_idx = cap_w + WIW'(1);
            if (cap_write) begin
               mem_we    = 1'b1;
               mem_be    = lane_mask[15:8];
               mem_wdata = lane_data[127:64];
            end else begin
               resp_d_n = extend(merged, cap_size, cap_sign);
            end
            resp_v_n = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         resp_v    <= 1'b0;
         resp_e    <= 1'b0;
         resp_d    <= 64'd0;
         hold      <= 64'd0;
         cap_w     <= '0;
         cap_off   <= 3'd0;
         cap_size  <= 2'd0;
         cap_sign  <= 1'b0;
         cap_write <= 1'b0;
         cap_wdata <= 64'd0;
      end else begin
         state  <= state_n;
         resp_v <= resp_v_n;
         resp_e <= resp_e_n;
         resp_d <= resp_d_n;
         hold   <= hold_n;
         if (cap_en) begin
            cap_w     <= req_w;
            cap_off   <= req_o;
            cap_size  <= bus.reqSize;
            cap_sign  <= bus.reqSignExtended;
            cap_write <= bus.reqWrite;
            cap_wdata <= bus.reqWriteData;
         end
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (mem_we && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   assign bus.respValid    = resp_v;
   assign bus.respError    = resp_e;
   assign bus.respReadData = resp_d;
endmodule

// File: tb/tb_data_memory_unit.sv
// Randomised bench for data_memory_unit: a byte-array reference model checked
// every cycle, plus directed cases with hand-computed results.
module tb_data_memory_unit;
   localparam int DEPTH = 2048;
   localparam int AW    = 11;

   logic clk = 1'b0;
   logic resetN;
   logic dbg_state;

   data_memory_unit_if #(.ADDR_WIDTH(64)) bus ();

   data_memory_unit #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(64)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   bit          run_cmp  = 1'b0;

   logic [7:0]  mm [DEPTH];
   bit          m_ready = 1'b1;
   logic        exp_v = 1'b0;
   logic        exp_e = 1'b0;
   logic [63:0] exp_d = 64'd0;
   bit          p_w;
   int          p_a, p_n, p_o;
   logic [1:0]  p_size;
   bit          p_sign;
   logic [63:0] p_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_load(input int a, input logic [1:0] size, input bit sign);
      int          n = 1 << size;
      logic [63:0] raw = 64'd0;
      logic [63:0] mask;
      for (int k = 0; k < n; k++) raw |= 64'(mm[a+k]) << (8*k);
      mask = (n == 8) ? '1 : ((64'd1 << (8*n)) - 64'd1);
      if (sign && raw[8*n-1]) raw |= ~mask;
      return raw;
   endfunction

   function automatic logic [63:0] m_word(input int a);
      return m_load(a, 2'd3, 1'b1);
   endfunction

   function automatic bit m_err(input bit w, input logic [63:0] a, input logic [1:0] size,
                                input bit sign);
      logic [63:0] n = 64'd1 << size;
      return ((a >> AW) != 0) || ((a + n) > 64'(DEPTH)) || (!w && size == 2'd3 && !sign);
   endfunction

   // Reference model: decides acceptance and the response due in the following cycle.
   always @(posedge clk) begin
      if (!resetN) begin
         m_ready = 1'b1;
         exp_v   = 1'b0;
         exp_e   = 1'b0;
         exp_d   = 64'd0;
      end else begin
         exp_v = 1'b0;
         exp_e = 1'b0;
         exp_d = 64'd0;
         if (!m_ready) begin
            if (p_w) begin
               for (int k = 8 - p_o; k < p_n; k++) mm[p_a+k] = p_data[8*k +: 8];
            end else begin
               exp_d = m_load(p_a, p_size, p_sign);
            end
            exp_v   = 1'b1;
            m_ready = 1'b1;
         end else if (bus.reqValid) begin
            if (m_err(bus.reqWrite, bus.reqAddress, bus.reqSize, bus.reqSignExtended)) begin
               exp_v = 1'b1;
               exp_e = 1'b1;
            end else begin
               p_w    = bus.reqWrite;
               p_a    = int'(bus.reqAddress[AW-1:0]);
               p_n    = 1 << bus.reqSize;
               p_o    = p_a % 8;
               p_size = bus.reqSize;
               p_sign = bus.reqSignExtended;
               p_data = bus.reqWriteData;
               if (p_o + p_n <= 8) begin
                  if (p_w) for (int k = 0; k < p_n; k++) mm[p_a+k] = p_data[8*k +: 8];
                  else exp_d = m_load(p_a, p_size, p_sign);
                  exp_v = 1'b1;
               end else begin
                  if (p_w) for (int k = 0; k < 8 - p_o; k++) mm[p_a+k] = p_data[8*k +: 8];
                  m_ready = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         if (!resetN) begin
            chk("rst_ready", {63'd0, bus.reqReady}, 64'd1);
            chk("rst_valid", {63'd0, bus.respValid}, 64'd0);
         end else begin
            chk("ready", {63'd0, bus.reqReady}, {63'd0, m_ready});
            chk("dbg_state", {63'd0, dbg_state}, {63'd0, !m_ready});
            chk("resp_valid", {63'd0, bus.respValid}, {63'd0, exp_v});
            if (exp_v) begin
               chk("resp_error", {63'd0, bus.respError}, {63'd0, exp_e});
               chk("resp_data", bus.respReadData, exp_d);
            end
         end
      end
   end

   task automatic send(input bit w, input logic [63:0] a, input logic [63:0] d,
                       input logic [1:0] s, input bit sg);
      int guard = 0;
      @(negedge clk);
      bus.reqWrite        = w;
      bus.reqAddress      = a;
      bus.reqWriteData    = d;
      bus.reqSize         = s;
      bus.reqSignExtended = sg;
      bus.reqValid        = 1'b1;
      while (!bus.reqReady && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      chk("accept_wait", {63'd0, bus.reqReady}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit w, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] s, input bit sg, output logic [63:0] rd,
                         output logic er, output int lat, output logic rdy1);
      send(w, a, d, s, sg);
      bus.reqValid = 1'b0;
      lat  = 99;
      rd   = 64'd0;
      er   = 1'b0;
      rdy1 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) rdy1 = bus.reqReady;
         if (bus.respValid && lat == 99) begin
            lat = i;
            rd  = bus.respReadData;
            er  = bus.respError;
         end
      end
   endtask

   initial begin
      #400000;
      n_checks++;
      n_err++;
      $display("FAIL watchdog time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd, pre18, pre20, pre40, pre48, pre7fe;
      logic        er, rdy1;
      int          lat, got;
      logic [63:0] a;

      resetN              = 1'b0;
      bus.reqValid        = 1'b0;
      bus.reqWrite        = 1'b0;
      bus.reqAddress      = 64'd0;
      bus.reqWriteData    = 64'd0;
      bus.reqSize         = 2'd0;
      bus.reqSignExtended = 1'b0;
      repeat (2) @(negedge clk);
      run_cmp = 1'b1;
      @(negedge clk);
      chk("reset_ready", {63'd0, bus.reqReady}, 64'd1);
      chk("reset_valid", {63'd0, bus.respValid}, 64'd0);
      chk("reset_data", bus.respReadData, 64'd0);
      chk("reset_error", {63'd0, bus.respError}, 64'd0);
      #1 resetN = 1'b1;

      // Give every byte a known value.
      for (int i = 0; i < DEPTH / 8; i++) send(1'b1, 64'(i * 8), {$urandom, $urandom}, 2'd3, 1'b0);
      bus.reqValid = 1'b0;

      do_req(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, rd, er, lat, rdy1);
      chk("store10_lat", 64'(lat), 64'd1);
      do_req(1'b0, 64'h10, 64'd0, 2'd3, 1'b1, rd, er, lat, rdy1);
      chk("load10_data", rd, 64'h1122334455667788);
      chk("load10_err", {63'd0, er}, 64'd0);
      chk("load10_lat", 64'(lat), 64'd1);
      do_req(1'b0, 64'h10, 64'd0, 2'd0, 1'b1, rd, er, lat, rdy1);
      chk("load10_b_sx", rd, 64'hFFFFFFFFFFFFFF88);
      do_req(1'b0, 64'h10, 64'd0, 2'd1, 1'b0, rd, er, lat, rdy1);
      chk("load10_h_zx", rd, 64'h7788);

      pre18 = m_word(32'h18);
      pre20 = m_word(32'h20);
      do_req(1'b1, 64'h1E, 64'hDEADBEEF, 2'd2, 1'b0, rd, er, lat, rdy1);
      chk("split_store_ready", {63'd0, rdy1}, 64'd0);
      chk("split_store_lat", 64'(lat), 64'd2);
      do_req(1'b0, 64'h1E, 64'd0, 2'd2, 1'b1, rd, er, lat, rdy1);
      chk("split_load_data", rd, 64'hFFFFFFFFDEADBEEF);
      chk("split_load_lat", 64'(lat), 64'd2);
      do_req(1'b0, 64'h18, 64'd0, 2'd3, 1'b1, rd, er, lat, rdy1);
      chk("split_word18", rd, {16'hBEEF, pre18[47:0]});
      do_req(1'b0, 64'h20, 64'd0, 2'd3, 1'b1, rd, er, lat, rdy1);
      chk("split_word20", rd, {pre20[63:16], 16'hDEAD});

      do_req(1'b0, 64'h7FC, 64'd0, 2'd3, 1'b1, rd, er, lat, rdy1);
      chk("err_7fc_err", {63'd0, er}, 64'd1);
      chk("err_7fc_data", rd, 64'd0);
      chk("err_7fc_lat", 64'(lat), 64'd1);
      do_req(1'b0, 64'h800, 64'd0, 2'd0, 1'b1, rd, er, lat, rdy1);
      chk("err_800_err", {63'd0, er}, 64'd1);
      do_req(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat, rdy1);
      chk("err_sign_err", {63'd0, er}, 64'd1);
      chk("err_sign_data", rd, 64'd0);
      pre7fe = m_load(32'h7FE, 2'd1, 1'b0);
      do_req(1'b1, 64'h7FE, 64'hCAFEF00D, 2'd2, 1'b0, rd, er, lat, rdy1);
      chk("err_store_err", {63'd0, er}, 64'd1);
      do_req(1'b0, 64'h7FE, 64'd0, 2'd1, 1'b0, rd, er, lat, rdy1);
      chk("err_store_intact", rd, pre7fe);

      // Reset during the second half of a split store.
      pre40 = m_word(32'h40);
      pre48 = m_word(32'h48);
      send(1'b1, 64'h44, 64'hA1A2A3A4A5A6A7A8, 2'd3, 1'b0);
      bus.reqValid = 1'b0;
      @(negedge clk);
      #1 resetN = 1'b0;
      got = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.respValid) got++;
      end
      chk("rst_split_no_resp", 64'(got), 64'd0);
      #1 resetN = 1'b1;
      @(negedge clk);
      chk("rst_split_ready", {63'd0, bus.reqReady}, 64'd1);
      do_req(1'b0, 64'h40, 64'd0, 2'd3, 1'b1, rd, er, lat, rdy1);
      chk("rst_split_word40", rd, {32'hA5A6A7A8, pre40[31:0]});
      do_req(1'b0, 64'h48, 64'd0, 2'd3, 1'b1, rd, er, lat, rdy1);
      chk("rst_split_word48", rd, pre48);

      // Back-to-back stream with reqValid held high.
      for (int i = 0; i < 8; i++) send(1'b1, 64'(32'h100 + 8*i), {$urandom, $urandom}, 2'd3, 1'b0);
      for (int i = 0; i < 8; i++) send(1'b0, 64'(32'h100 + 8*i), 64'd0, 2'd3, 1'b1);
      bus.reqValid = 1'b0;

      // Random traffic including idle gaps, splits and errors.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            bus.reqValid = 1'b0;
            @(posedge clk);
            #1;
         end else begin
            case ($urandom_range(0, 15))
               0:       a = 64'(DEPTH + $urandom_range(0, 64));
               1:       a = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, DEPTH - 1));
               2, 3:    a = 64'(DEPTH - $urandom_range(1, 8));
               default: a = 64'($urandom_range(0, DEPTH - 1));
            endcase
            send(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end
      end
      bus.reqValid = 1'b0;

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
